// File: rtl/key_buffer_pkg.sv
// ============================================================================
// Module  : key_buffer_pkg
// Purpose : Shared definitions for the PS/2 digit key buffer. Holds the
//           parser state encoding, the scan-set-2 prefix codes (F0 break,
//           E0 extended), the ten digit make codes and a lookup helper that
//           maps a scan code to its digit value.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package key_buffer_pkg;

  // Parser states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // waiting for a make code or a prefix
    ST_BRK     = 2'd1,  // F0 seen: next byte is a released key
    ST_EXT     = 2'd2,  // E0 seen: next byte is an extended key
    ST_EXT_BRK = 2'd3   // E0 F0 seen: next byte is a released extended key
  } state_t;

  // Prefix codes.
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Digit make codes (main keyboard row).
  localparam logic [7:0] SC_DIGIT_0 = 8'h45;
  localparam logic [7:0] SC_DIGIT_1 = 8'h16;
  localparam logic [7:0] SC_DIGIT_2 = 8'h1E;
  localparam logic [7:0] SC_DIGIT_3 = 8'h26;
  localparam logic [7:0] SC_DIGIT_4 = 8'h25;
  localparam logic [7:0] SC_DIGIT_5 = 8'h2E;
  localparam logic [7:0] SC_DIGIT_6 = 8'h36;
  localparam logic [7:0] SC_DIGIT_7 = 8'h3D;
  localparam logic [7:0] SC_DIGIT_8 = 8'h3E;
  localparam logic [7:0] SC_DIGIT_9 = 8'h46;

  typedef struct packed {
    logic       hit;  // code is one of the ten digit make codes
    logic [3:0] num;  // digit value when hit, else 0
  } digit_t;

  function automatic digit_t digit_lookup(input logic [7:0] code);
    digit_t d;
    d.hit = 1'b1;
    d.num = 4'd0;
    case (code)
      SC_DIGIT_0: d.num = 4'd0;
      SC_DIGIT_1: d.num = 4'd1;
      SC_DIGIT_2: d.num = 4'd2;
      SC_DIGIT_3: d.num = 4'd3;
      SC_DIGIT_4: d.num = 4'd4;
      SC_DIGIT_5: d.num = 4'd5;
      SC_DIGIT_6: d.num = 4'd6;
      SC_DIGIT_7: d.num = 4'd7;
      SC_DIGIT_8: d.num = 4'd8;
      SC_DIGIT_9: d.num = 4'd9;
      default:    d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage : key_buffer_pkg

`default_nettype wire

// File: rtl/key_buffer_if.sv
// ============================================================================
// Module  : key_buffer_if
// Purpose : Bundles the scan-byte input strobe and the digit output
//           handshake of key_buffer.
// Ports   : in_valid/in_byte  scan byte strobe (master -> slave)
//           out_ready         consumer pop request (master -> slave)
//           out_valid/out_num head digit (slave -> master)
//           count/overflow    occupancy and sticky drop flag (slave -> master)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface key_buffer_if #(
  parameter int CNT_WIDTH = 4
);
  import key_buffer_pkg::*;

  logic                 in_valid;
  logic [7:0]           in_byte;
  logic                 out_ready;
  logic                 out_valid;
  logic [3:0]           out_num;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;

  // Master: keyboard receiver plus digit consumer.
  modport master (
    output in_valid, in_byte, out_ready,
    input  out_valid, out_num, count, overflow
  );

  // Slave: the key buffer itself.
  modport slave (
    input  in_valid, in_byte, out_ready,
    output out_valid, out_num, count, overflow
  );

endinterface : key_buffer_if

`default_nettype wire

// File: rtl/key_buffer_num_fifo.sv
// ============================================================================
// Module  : num_fifo
// Purpose : Synchronous FIFO of 4-bit digits, DEPTH entries (power of two).
//           A push while full is accepted only when a pop happens in the
//           same cycle; otherwise it is refused and the caller decides what
//           to do about it.
// Ports   : clk, rst           clock, synchronous active-high reset
//           push, push_data    write request and data
//           pop                read request (ignored while empty)
//           head               data at the read pointer
//           count, full, empty occupancy status
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module num_fifo #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [3:0]           push_data,
  input  logic                 pop,
  output logic [3:0]           head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);

  logic [3:0]           mem_q [DEPTH];
  logic [3:0]           mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push_ok;
  logic                 pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == C_DEPTH);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // When full, the slot being popped is the one the write lands in, so a
  // simultaneous pop frees exactly the room the push needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);  // wraps modulo DEPTH
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : num_fifo

`default_nettype wire

// File: rtl/key_buffer.sv
// ============================================================================
// Module  : key_buffer
// Purpose : Parses PS/2 scan-set-2 bytes, extracts digit key presses
//           (suppressing typematic repeats of the held key) and queues the
//           digit values in a FIFO for a downstream consumer.
// Ports   : clk   single clock, rising edge
//           rst   synchronous active-high reset
//           bus   key_buffer_if.slave: in_valid/in_byte scan strobe,
//                 out_ready/out_valid/out_num pop handshake, count,
//                 sticky overflow
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_buffer
  import key_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  key_buffer_if.slave   bus
);

  state_t     state_q, state_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_valid_q, held_valid_d;
  logic       overflow_q, overflow_d;
  logic       push_req;
  logic [3:0] push_num;
  digit_t     dig;

  logic [3:0]           fifo_head;
  logic [CNT_WIDTH-1:0] fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop_req;

  assign dig     = digit_lookup(bus.in_byte);
  assign pop_req = bus.out_ready & ~fifo_empty;

  // Parser and held-key tracking.
  always_comb begin
    state_d      = state_q;
    held_code_d  = held_code_q;
    held_valid_d = held_valid_q;
    push_req     = 1'b0;
    push_num     = 4'd0;
    if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_byte == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (bus.in_byte == SC_EXT) begin
            state_d = ST_EXT;
          end else if (dig.hit) begin
            // A repeated make of the key still held down is typematic.
            if (!(held_valid_q && (bus.in_byte == held_code_q))) begin
              push_req     = 1'b1;
              push_num     = dig.num;
              held_code_d  = bus.in_byte;
              held_valid_d = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (held_valid_q && (bus.in_byte == held_code_q)) begin
            held_valid_d = 1'b0;
          end
        end
        ST_EXT: begin
          state_d = (bus.in_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: begin  // ST_EXT_BRK
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // A digit is lost only when the FIFO is full and nothing leaves this cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (push_req && fifo_full && !pop_req) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      held_code_q  <= 8'h00;
      held_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_code_q  <= held_code_d;
      held_valid_q <= held_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  num_fifo #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_num_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_num),
    .pop       (pop_req),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_num   = fifo_empty ? 4'h0 : fifo_head;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;

endmodule : key_buffer

`default_nettype wire

// File: tb/tb_key_buffer.sv
// ============================================================================
// Module  : tb_key_buffer
// Purpose : Directed self-checking bench for key_buffer (DEPTH=8).
//           Inputs change 1 ns after the rising edge; outputs are checked
//           at the same point, i.e. after the edge has taken effect.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_buffer;

  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  key_buffer_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  key_buffer #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the stimulus is a fixed length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---- stimulus helpers --------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pop);
    bus.in_valid  = 1'b1;
    bus.in_byte   = b;
    bus.out_ready = pop;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic idle(input logic pop);
    bus.out_ready = pop;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---- tests -------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_num !== 4'h0) $display("FAIL reset_out_num: got %h want 0", bus.out_num);
    else pass_cnt++;
    total_cnt++;
    if (bus.count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.count);
    else pass_cnt++;
    total_cnt++;
    if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow);
    else pass_cnt++;
    // reset wins over a simultaneous digit strobe
    rst = 1'b1;
    send(8'h16, 1'b0);
    rst = 1'b0;
    total_cnt++;
    if (bus.count !== 4'd0) $display("FAIL reset_overrides_push: count got %0d want 0", bus.count);
    else pass_cnt++;
  endtask

  task automatic test_push_latency();
    do_reset();
    send(8'h16, 1'b0);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_num !== 4'd1 || bus.count !== 4'd1)
      $display("FAIL push_latency: got valid=%b num=%0d count=%0d want 1/1/1",
               bus.out_valid, bus.out_num, bus.count);
    else pass_cnt++;
  endtask

  task automatic test_typematic();
    do_reset();
    send(8'h16, 1'b0);
    send(8'h16, 1'b0);
    send(8'h16, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h16, 1'b0);
    send(8'h16, 1'b0);
    total_cnt++;
    if (bus.count !== 4'd2 || bus.out_num !== 4'd1)
      $display("FAIL typematic_count: got count=%0d num=%0d want 2/1", bus.count, bus.out_num);
    else pass_cnt++;
    idle(1'b1);
    total_cnt++;
    if (bus.count !== 4'd1 || bus.out_num !== 4'd1)
      $display("FAIL typematic_second: got count=%0d num=%0d want 1/1", bus.count, bus.out_num);
    else pass_cnt++;
    idle(1'b1);
    total_cnt++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_num !== 4'h0)
      $display("FAIL typematic_drain: got count=%0d valid=%b num=%0d want 0/0/0",
               bus.count, bus.out_valid, bus.out_num);
    else pass_cnt++;
  endtask

  task automatic test_extended();
    do_reset();
    send(8'hE0, 1'b0);
    send(8'h45, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h45, 1'b0);
    send(8'h1C, 1'b0);  // non-digit in IDLE
    total_cnt++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0)
      $display("FAIL extended_no_push: got count=%0d valid=%b want 0/0", bus.count, bus.out_valid);
    else pass_cnt++;
    send(8'h45, 1'b0);
    total_cnt++;
    if (bus.count !== 4'd1 || bus.out_valid !== 1'b1 || bus.out_num !== 4'd0)
      $display("FAIL extended_then_digit0: got count=%0d valid=%b num=%0d want 1/1/0",
               bus.count, bus.out_valid, bus.out_num);
    else pass_cnt++;
  endtask

  task automatic test_empty_pop();
    do_reset();
    idle(1'b1);
    idle(1'b1);
    total_cnt++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0)
      $display("FAIL empty_pop: got count=%0d valid=%b ovf=%b want 0/0/0",
               bus.count, bus.out_valid, bus.overflow);
    else pass_cnt++;
  endtask

  // Nine alternating 1/2 presses into an 8-deep FIFO, then push 9 with a pop.
  task automatic test_overflow();
    logic [3:0] exp_q [$];
    do_reset();
    for (int i = 0; i < 9; i++) send((i % 2 == 0) ? 8'h16 : 8'h1E, 1'b0);
    total_cnt++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b1 || bus.out_num !== 4'd1)
      $display("FAIL overflow_full: got count=%0d ovf=%b head=%0d want 8/1/1",
               bus.count, bus.overflow, bus.out_num);
    else pass_cnt++;
    send(8'h46, 1'b1);
    total_cnt++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b1 || bus.out_num !== 4'd2)
      $display("FAIL overflow_push_pop: got count=%0d ovf=%b head=%0d want 8/1/2",
               bus.count, bus.overflow, bus.out_num);
    else pass_cnt++;
    exp_q = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd9};
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_num !== exp_q[i])
        $display("FAIL overflow_drain[%0d]: got valid=%b num=%0d want 1/%0d",
                 i, bus.out_valid, bus.out_num, exp_q[i]);
      else pass_cnt++;
      idle(1'b1);
    end
    total_cnt++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b1)
      $display("FAIL overflow_sticky: got count=%0d valid=%b ovf=%b want 0/0/1",
               bus.count, bus.out_valid, bus.overflow);
    else pass_cnt++;
    // pointers have wrapped; a fresh push must still come out correctly
    send(8'h3D, 1'b0);
    total_cnt++;
    if (bus.count !== 4'd1 || bus.out_num !== 4'd7)
      $display("FAIL wrap_push: got count=%0d num=%0d want 1/7", bus.count, bus.out_num);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 8'h25 : 8'h2E, 1'b0);
    send(8'h36, 1'b1);
    total_cnt++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b0 || bus.out_num !== 4'd5)
      $display("FAIL full_push_pop: got count=%0d ovf=%b head=%0d want 8/0/5",
               bus.count, bus.overflow, bus.out_num);
    else pass_cnt++;
  endtask

  task automatic test_reset_prefix();
    do_reset();
    send(8'hF0, 1'b0);
    do_reset();
    send(8'h26, 1'b0);
    total_cnt++;
    if (bus.count !== 4'd1 || bus.out_valid !== 1'b1 || bus.out_num !== 4'd3)
      $display("FAIL reset_prefix: got count=%0d valid=%b num=%0d want 1/1/3",
               bus.count, bus.out_valid, bus.out_num);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_push_latency();
    test_typematic();
    test_extended();
    test_empty_pop();
    test_overflow();
    test_full_push_pop();
    test_reset_prefix();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_key_buffer

`default_nettype wire
